sc_sequencer: RTL



---
 rtl/sc_sequencer.sv | 82 ++++++++
 1 files changed

// File: rtl/sc_sequencer.sv
// Sequence-counter controller: S/R flip-flops, 4-bit SC for the T0..T15 decoder, completed-instruction counter.
// Optional runaway watchdog enabled by defining SC_WATCHDOG_EN.
module sc_sequencer #(
  parameter int MAX_T  = 15,
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              sc_clr,
  input  logic              mem_busy,
  input  logic              ien,
  input  logic              irq,
  output logic [3:0]        code,
  output logic              running,
  output logic              r_cycle,
  output logic              stalled,
  output logic [ICNT_W-1:0] instr_cnt,
  output logic              err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [3:0] MAX_CODE = 4'(MAX_T);

  logic [0:0] state;
  logic       start_ok;
  logic       count_done;

`ifdef SC_WATCHDOG_EN
  logic err_q;
  assign err      = err_q;
  assign start_ok = start && !err_q;
`else
  assign err      = 1'b0;
  assign start_ok = start;
`endif

  assign running    = (state == S_RUN);
  assign stalled    = (state == S_RUN) && mem_busy && !halt && !sc_clr;
  // The interrupt cycle is not a normal instruction, so it never counts.
  assign count_done = (state == S_RUN) && (halt || sc_clr) && !r_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      code    <= 4'd0;
      r_cycle <= 1'b0;
`ifdef SC_WATCHDOG_EN
      err_q   <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      code <= 4'd0;
      if (start_ok) state <= S_RUN;
    end else if (halt) begin
      state   <= S_IDLE;
      code    <= 4'd0;
      r_cycle <= 1'b0;
    end else if (sc_clr) begin
      code    <= 4'd0;
      r_cycle <= r_cycle ? 1'b0 : (ien && irq);
    end else if (mem_busy) begin
      code <= code;
    end else if (code == MAX_CODE) begin
      code <= 4'd0;
`ifdef SC_WATCHDOG_EN
      state   <= S_IDLE;
      r_cycle <= 1'b0;
      err_q   <= 1'b1;
`endif
    end else begin
      code <= code + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_cnt <= '0;
    else if (count_done) instr_cnt <= instr_cnt + ICNT_W'(1);
  end

endmodule
